// File: rtl/font16_line_reader.sv
// Font ROM scanline reader: fetches one glyph row per character from a
// synchronous 256x8 ROM and serialises the line as a 1-bit valid/ready stream.
module font16_line_reader #(
  parameter int NUM_CHARS   = 4,
  parameter int ROM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [3:0]             row,
  input  logic [4*NUM_CHARS-1:0] glyphs,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             rom_ad,
  output logic                   rom_ce,
  output logic                   rom_oce,
  output logic                   rom_reset,
  input  logic [7:0]             rom_dout,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   pix_data,
  output logic                   pix_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_CHARS);

  state_t                 state_q;
  logic                   busy_q, done_q;
  logic [3:0]             row_q;
  logic [4*NUM_CHARS-1:0] glyphs_q;
  logic [4:0]             f_q, e_q;
  logic [ROM_LATENCY-1:0] inflight_q;
  logic [7:0]             buf_q, sh_q;
  logic                   buf_vld_q;
  logic [3:0]             cnt_q;

  logic [3:0] glyph_cur;
  logic       issue, capture, hs, load, last_hs;

  always_comb begin
    glyph_cur = 4'h0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (f_q == 5'(i)) glyph_cur = glyphs_q[4*i +: 4];
    end
  end

  // One outstanding read at a time, and only into an empty buffer, so no
  // returning byte can ever find the buffer occupied.
  assign issue   = (state_q == S_RUN) && (f_q < LAST_IDX) && !buf_vld_q && (inflight_q == '0);
  assign capture = inflight_q[ROM_LATENCY-1];
  assign hs      = pix_valid && pix_ready;
  assign load    = buf_vld_q && ((cnt_q == 4'd0) || ((cnt_q == 4'd1) && hs));
  assign last_hs = hs && pix_last;

  assign rom_ce    = issue;
  assign rom_ad    = issue ? {glyph_cur, row_q} : 8'h00;
  assign rom_oce   = 1'b1;
  assign rom_reset = 1'b0;

  assign pix_valid = (cnt_q != 4'd0);
  assign pix_data  = sh_q[7];
  assign pix_last  = pix_valid && (cnt_q == 4'd1) && (e_q == LAST_IDX);
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      row_q      <= 4'h0;
      glyphs_q   <= '0;
      f_q        <= 5'd0;
      e_q        <= 5'd0;
      inflight_q <= '0;
      buf_q      <= 8'h00;
      buf_vld_q  <= 1'b0;
      sh_q       <= 8'h00;
      cnt_q      <= 4'd0;
    end else if (abort) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      f_q        <= 5'd0;
      e_q        <= 5'd0;
      inflight_q <= '0;
      buf_vld_q  <= 1'b0;
      sh_q       <= 8'h00;
      cnt_q      <= 4'd0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= (inflight_q << 1) | ROM_LATENCY'(issue);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            row_q    <= row;
            glyphs_q <= glyphs;
            f_q      <= 5'd0;
            e_q      <= 5'd0;
          end
        end
        S_RUN: begin
          if (issue) f_q <= f_q + 5'd1;
          if (hs) begin
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_q - 4'd1;
          end
          // Reloading on the last-pixel handshake keeps the stream gapless.
          if (load) begin
            sh_q      <= buf_q;
            cnt_q     <= 4'd8;
            e_q       <= e_q + 5'd1;
            buf_vld_q <= 1'b0;
          end
          if (capture) begin
            buf_q     <= rom_dout;
            buf_vld_q <= 1'b1;
          end
          if (last_hs) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_font16_line_reader.sv
// Drives four reader configurations with shared stimulus; each has its own ROM
// model and a monitor checking addresses, pixels, timing and flow control.
module tb_font16_line_reader;

  localparam int NI = 4;
  localparam int NC [NI] = '{1, 2, 4, 4};
  localparam int LT [NI] = '{1, 1, 1, 6};

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [3:0]  row;
  logic [63:0] glyphs_all;
  logic        pix_ready;
  logic [7:0]  rom [256];
  int          cyc;
  int          rdy_mode;
  int          n_checks;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g
    localparam int N = NC[gi];
    localparam int L = LT[gi];

    logic [4*N-1:0] gl;
    logic           busy, done, ce, oce, rrst, pv, pd, pl;
    logic [7:0]     ad, dout;
    logic [7:0]     pipe [L];

    assign gl = glyphs_all[4*N-1:0];

    font16_line_reader #(.NUM_CHARS(N), .ROM_LATENCY(L)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .row(row), .glyphs(gl), .busy(busy), .done(done),
      .rom_ad(ad), .rom_ce(ce), .rom_oce(oce), .rom_reset(rrst),
      .rom_dout(dout), .pix_valid(pv), .pix_ready(pix_ready),
      .pix_data(pd), .pix_last(pl)
    );

    // ROM: data for a ce in cycle T appears in cycle T+L; garbage otherwise.
    always @(posedge clk) begin
      pipe[0] <= ce ? rom[ad] : 8'($urandom);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign dout = pipe[L-1];

    bit         exp_q [$];
    logic [7:0] exp_ad [$];
    logic [7:0] got_bytes [16];
    logic [7:0] ce1_ad;
    int start_cyc, first_cyc, last_hs_cyc, done_cyc, ce1_cyc;
    int n_valid, n_hs, n_ce, n_done, nbits;
    bit active, first_seen, prev_stall, prev_d, prev_l, done_prev, post_abort, all_ready;

    function automatic string tg(input string s);
      return $sformatf("i%0d_%s", gi, s);
    endfunction

    initial begin
      n_done = 0;
      active = 0;
    end

    always @(negedge clk) begin : mon
      logic [7:0] a, b;
      bit e;
      if (!reset_n) begin
        active = 0; exp_q.delete(); exp_ad.delete();
        prev_stall = 0; done_prev = 0; post_abort = 0;
      end else begin
        if (post_abort) begin
          chk(tg("abort_idle"), {busy, pv}, 0);
          post_abort = 0;
        end
        if (done_prev) chk(tg("busy_after_done"), busy, 0);
        done_prev = done;
        if (done) begin
          n_done++; done_cyc = cyc;
          chk(tg("done_active"), active, 1);
          chk(tg("done_cyc"), cyc - last_hs_cyc, 1);
          chk(tg("ce_left"), exp_ad.size(), 0);
          active = 0;
        end
        if (prev_stall) begin
          chk(tg("stall_valid"), pv, 1);
          chk(tg("stall_data"), pd, prev_d);
          chk(tg("stall_last"), pl, prev_l);
        end
        if (ce) begin
          chk(tg("ce_expected"), exp_ad.size() > 0, 1);
          if (n_ce == 0) begin ce1_cyc = cyc; ce1_ad = ad; end
          n_ce++;
          if (exp_ad.size() > 0) chk(tg("rom_ad"), ad, exp_ad.pop_front());
        end
        if (pv) begin
          n_valid++;
          if (!first_seen) begin
            first_seen = 1; first_cyc = cyc;
            chk(tg("first_pix_cyc"), cyc - start_cyc, 3 + L);
          end
        end
        if (pv && pix_ready) begin
          chk(tg("pix_expected"), exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tg("pix_data"), pd, e);
            chk(tg("pix_last"), pl, exp_q.size() == 0);
            if (nbits < 128) got_bytes[nbits/8][7 - nbits%8] = pd;
            nbits++; n_hs++;
            last_hs_cyc = cyc;
            if (exp_q.size() == 0 && all_ready) chk(tg("gapless"), cyc - first_cyc, 8*N - 1);
          end
        end
        prev_stall = pv && !pix_ready; prev_d = pd; prev_l = pl;
        if (abort) begin
          active = 0; exp_q.delete(); exp_ad.delete();
          prev_stall = 0; post_abort = 1;
        end else if (start && !busy) begin
          active = 1; first_seen = 0; start_cyc = cyc;
          n_valid = 0; n_hs = 0; n_ce = 0; nbits = 0;
          all_ready = (rdy_mode == 0);
          exp_q.delete(); exp_ad.delete();
          for (int c = 0; c < 16; c++) got_bytes[c] = 8'h00;
          for (int c = 0; c < N; c++) begin
            a = {glyphs_all[4*c +: 4], row};
            b = rom[a];
            exp_ad.push_back(a);
            for (int k = 7; k >= 0; k--) exp_q.push_back(b[k]);
          end
        end
      end
    end
  end

  function automatic bit any_active();
    return g[0].active | g[1].active | g[2].active | g[3].active;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ~pix_ready;
      default: pix_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic start_line(input logic [3:0] r, input logic [63:0] gls, input int mode);
    rdy_mode   = mode;
    pix_ready  = 1'b1;
    row        = r;
    glyphs_all = gls;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (any_active() && n < 500) begin
      tick();
      n++;
    end
    chk("line_timeout", any_active(), 0);
    tick();
    tick();
  endtask

  initial begin
    int s, d0, k;
    n_checks = 0; n_fail = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h14] = 8'h78;
    rom[8'h12] = 8'h18;
    rom[8'h22] = 8'h7C;
    rom[8'h93] = 8'hC6;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; row = 4'h0;
    glyphs_all = '0; pix_ready = 1'b1; rdy_mode = 0;
    repeat (3) tick();
    chk("rst_i0", {g[0].busy, g[0].done, g[0].ce, g[0].pv, g[0].pd, g[0].pl, g[0].ad}, 0);
    chk("rst_i3", {g[3].busy, g[3].done, g[3].ce, g[3].pv, g[3].pd, g[3].pl, g[3].ad}, 0);
    chk("tie_oce_rst", {g[0].oce, g[0].rrst}, 2'b10);
    reset_n = 1'b1;
    tick();

    start_line(4'd4, 64'h1, 0);
    wait_idle();
    s = g[0].start_cyc;
    chk("t1_ce_cyc", g[0].ce1_cyc - s, 1);
    chk("t1_ce_ad", g[0].ce1_ad, 8'h14);
    chk("t1_first", g[0].first_cyc - s, 4);
    chk("t1_byte", g[0].got_bytes[0], 8'h78);
    chk("t1_last", g[0].last_hs_cyc - s, 11);
    chk("t1_done", g[0].done_cyc - s, 12);

    start_line(4'd2, 64'h21, 0);
    wait_idle();
    chk("t2_byte0", g[1].got_bytes[0], 8'h18);
    chk("t2_byte1", g[1].got_bytes[1], 8'h7C);
    chk("t2_n_ce", g[1].n_ce, 2);
    chk("t2_n_valid", g[1].n_valid, 16);

    start_line(4'd2, 64'h21, 1);
    wait_idle();
    chk("t3_byte0", g[1].got_bytes[0], 8'h18);
    chk("t3_byte1", g[1].got_bytes[1], 8'h7C);
    chk("t3_n_hs", g[1].n_hs, 16);

    start_line(4'($urandom), {$urandom, $urandom}, 0);
    wait_idle();
    chk("t4_first", g[3].first_cyc - g[3].start_cyc, 9);
    chk("t4_n_valid", g[3].n_valid, 32);

    start_line(4'($urandom), {$urandom, $urandom}, 0);
    s  = g[2].start_cyc;
    d0 = g[2].n_done;
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    start_line(4'd3, 64'h0009, 0);
    wait_idle();
    chk("t5_first", g[2].first_cyc - s, 12);
    chk("t5_byte", g[2].got_bytes[0], 8'hC6);
    chk("t5_done", g[2].n_done, d0 + 1);

    start_line(4'($urandom), {$urandom, $urandom}, 0);
    repeat (6) tick();
    reset_n = 1'b0;
    #1;
    chk("t6_rst_i2", {g[2].busy, g[2].done, g[2].ce, g[2].pv, g[2].pd, g[2].pl, g[2].ad}, 0);
    chk("t6_rst_i3", {g[3].busy, g[3].done, g[3].ce, g[3].pv, g[3].pd, g[3].pl, g[3].ad}, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    d0 = g[2].n_done;
    start_line(4'($urandom), {$urandom, $urandom}, 0);
    wait_idle();
    chk("t6_fresh_done", g[2].n_done, d0 + 1);

    for (int it = 0; it < 25; it++) begin
      start_line(4'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 2)));
      k = $urandom_range(2, 40);
      repeat (k) tick();
      if ($urandom_range(0, 4) == 0) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end else begin
        glyphs_all = {$urandom, $urandom};
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
